// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN-order car sequencer.
// Holds pending requests, moves the car floor by floor and runs the door dwell.
module elevator_scheduler #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [15:0]           req_floor,
  output logic                  req_ready,
  output logic                  req_err,
  output logic [15:0]           current_floor,
  output logic [15:0]           nextfloor,
  output logic                  up,
  output logic                  down,
  output logic                  door_open,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int NF = NUM_FLOORS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;

  localparam logic [15:0] NF_W    = 16'(NUM_FLOORS);
  localparam logic [15:0] TRV_LD  = 16'(TRAVEL_CYCLES - 1);
  localparam logic [15:0] DOOR_LD = 16'(DOOR_CYCLES - 1);

  typedef logic [NF-1:0] mask_t;

  function automatic mask_t onehot(input logic [15:0] f);
    mask_t m;
    m = '0;
    for (int i = 0; i < NF; i++) m[i] = (16'(i) == f);
    return m;
  endfunction

  function automatic mask_t above(input logic [15:0] f);
    mask_t m;
    m = '0;
    for (int i = 0; i < NF; i++) m[i] = (16'(i) > f);
    return m;
  endfunction

  function automatic mask_t below(input logic [15:0] f);
    mask_t m;
    m = '0;
    for (int i = 0; i < NF; i++) m[i] = (16'(i) < f);
    return m;
  endfunction

  function automatic logic [15:0] lowest(input mask_t m);
    logic [15:0] r;
    r = '0;
    for (int i = NF - 1; i >= 0; i--) if (m[i]) r = 16'(i);
    return r;
  endfunction

  function automatic logic [15:0] highest(input mask_t m);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < NF; i++) if (m[i]) r = 16'(i);
    return r;
  endfunction

  // any request strictly beyond floor f in direction d (1 = up)
  function automatic logic ahead(input mask_t p,
                                 input logic [15:0] f,
                                 input logic d);
    return d ? |(p & above(f)) : |(p & below(f));
  endfunction

  logic [1:0]  state_q, state_d;
  logic        dir_q, dir_d;
  logic [15:0] cf_q, cf_d;
  logic [15:0] nf_q, nf_d;
  mask_t       pend_q, pend_d;
  logic [15:0] trav_q, trav_d;
  logic [15:0] door_q, door_d;
  logic        arr_q, arr_d;
  logic        err_q, err_d;

  logic        req_ok;
  logic        door_hit;
  mask_t       set_m;
  mask_t       clr_m;
  mask_t       up_set;
  mask_t       dn_set;
  logic [15:0] step_f;

  assign req_ready     = !rst;
  assign req_err       = err_q;
  assign current_floor = cf_q;
  assign nextfloor     = nf_q;
  assign up            = (state_q == S_MOVE) && dir_q;
  assign down          = (state_q == S_MOVE) && !dir_q;
  assign door_open     = (state_q == S_DOOR);
  assign arrived       = arr_q;
  assign pending       = pend_q;

  // nearest pending floor, preferring the travel direction
  always_comb begin
    up_set = pend_q & above(cf_q);
    dn_set = pend_q & below(cf_q);
    nf_d   = cf_q;
    if (dir_q) begin
      if (|up_set)      nf_d = lowest(up_set);
      else if (|dn_set) nf_d = highest(dn_set);
    end else begin
      if (|dn_set)      nf_d = highest(dn_set);
      else if (|up_set) nf_d = lowest(up_set);
    end
  end

  // car sequencing and request bookkeeping
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cf_d     = cf_q;
    trav_d   = trav_q;
    door_d   = door_q;
    arr_d    = 1'b0;
    clr_m    = '0;
    step_f   = dir_q ? cf_q + 16'd1 : cf_q - 16'd1;
    req_ok   = req_valid && (req_floor < NF_W);
    door_hit = req_valid && (state_q == S_DOOR)
               && (req_floor == cf_q);
    err_d    = req_valid && !req_ok;
    set_m    = (req_ok && !door_hit) ? onehot(req_floor) : '0;

    unique case (state_q)
      S_IDLE: begin
        if (|(pend_q & onehot(cf_q))) begin
          clr_m   = onehot(cf_q);
          arr_d   = 1'b1;
          state_d = S_DOOR;
          door_d  = DOOR_LD;
        end else if (ahead(pend_q, cf_q, dir_q)) begin
          state_d = S_MOVE;
          trav_d  = TRV_LD;
        end else if (ahead(pend_q, cf_q, !dir_q)) begin
          dir_d   = !dir_q;
          state_d = S_MOVE;
          trav_d  = TRV_LD;
        end
      end
      S_MOVE: begin
        if (trav_q == 16'd0) begin
          cf_d   = step_f;
          trav_d = TRV_LD;
          if (|(pend_q & onehot(step_f))) begin
            clr_m   = onehot(step_f);
            arr_d   = 1'b1;
            state_d = S_DOOR;
            door_d  = DOOR_LD;
          end else if (!ahead(pend_q, step_f, dir_q)) begin
            state_d = S_IDLE;
          end
        end else begin
          trav_d = trav_q - 16'd1;
        end
      end
      S_DOOR: begin
        if (door_hit) begin
          door_d = DOOR_LD;
        end else if (door_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          door_d = door_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pend_d = (pend_q | set_m) & ~clr_m;
  end

  // state registers; reset puts the car back at floor 0, heading up
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b1;
      cf_q    <= '0;
      nf_q    <= '0;
      pend_q  <= '0;
      trav_q  <= '0;
      door_q  <= '0;
      arr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cf_q    <= cf_d;
      nf_q    <= nf_d;
      pend_q  <= pend_d;
      trav_q  <= trav_d;
      door_q  <= door_d;
      arr_q   <= arr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed scenarios plus random traffic
// checked against a floor-search reference model.
module tb_elevator_scheduler;

  localparam int NF = 8;
  localparam int TC = 4;
  localparam int DC = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [15:0]   req_floor;
  logic          req_ready;
  logic          req_err;
  logic [15:0]   current_floor;
  logic [15:0]   nextfloor;
  logic          up;
  logic          down;
  logic          door_open;
  logic          arrived;
  logic [NF-1:0] pending;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  elevator_scheduler #(
    .NUM_FLOORS(NF),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_floor(req_floor),
    .req_ready(req_ready),
    .req_err(req_err),
    .current_floor(current_floor),
    .nextfloor(nextfloor),
    .up(up),
    .down(down),
    .door_open(door_open),
    .arrived(arrived),
    .pending(pending)
  );

  // reference model: mode 0 idle, 1 moving, 2 door open
  int m_floor, m_next, m_mode, m_tleft, m_dleft;
  bit m_dir, m_arr, m_err;
  bit m_pend [NF];

  function automatic int nearest(int f, int d);
    for (int k = f + d; k >= 0 && k < NF; k += d)
      if (m_pend[k]) return k;
    return -1;
  endfunction

  function automatic logic [NF-1:0] m_pend_vec();
    logic [NF-1:0] v;
    for (int i = 0; i < NF; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_update();
    int s, nf, setf, clrf;
    if (rst) begin
      m_floor = 0; m_next = 0; m_mode = 0; m_tleft = 0; m_dleft = 0;
      m_dir = 1; m_arr = 0; m_err = 0;
      for (int i = 0; i < NF; i++) m_pend[i] = 0;
      return;
    end
    s  = m_dir ? 1 : -1;
    nf = nearest(m_floor, s);
    if (nf < 0) nf = nearest(m_floor, -s);
    if (nf < 0) nf = m_floor;
    m_err = req_valid && (int'(req_floor) >= NF);
    setf  = -1;
    clrf  = -1;
    m_arr = 0;
    if (req_valid && int'(req_floor) < NF &&
        !(m_mode == 2 && int'(req_floor) == m_floor))
      setf = int'(req_floor);
    case (m_mode)
      0: begin
        if (m_pend[m_floor]) begin
          clrf = m_floor; m_arr = 1; m_mode = 2; m_dleft = DC;
        end else if (nearest(m_floor, s) >= 0) begin
          m_mode = 1; m_tleft = TC;
        end else if (nearest(m_floor, -s) >= 0) begin
          m_dir = !m_dir; m_mode = 1; m_tleft = TC;
        end
      end
      1: begin
        m_tleft--;
        if (m_tleft == 0) begin
          m_floor += s;
          m_tleft = TC;
          if (m_pend[m_floor]) begin
            clrf = m_floor; m_arr = 1; m_mode = 2; m_dleft = DC;
          end else if (nearest(m_floor, s) < 0) begin
            m_mode = 0;
          end
        end
      end
      default: begin
        if (req_valid && int'(req_floor) == m_floor) m_dleft = DC;
        else begin
          m_dleft--;
          if (m_dleft == 0) m_mode = 0;
        end
      end
    endcase
    if (setf >= 0) m_pend[setf] = 1;
    if (clrf >= 0) m_pend[clrf] = 0;
    m_next = nf;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; req_floor = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic request(input int f);
    req_valid = 1'b1; req_floor = 16'(f);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_arrival(output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (arrived === 1'b1) ok = 1;
    end
  endtask

  task automatic wait_door_closed(output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (door_open === 1'b0) ok = 1;
    end
  endtask

  task automatic wait_floor_up(input int f, output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (up === 1'b1 && int'(current_floor) == f) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_floor = 16'd5;
    tick(); tick(); tick();
    checks++;
    if (req_ready !== 1'b0) begin
      fails++; $display("FAIL rst_ready got %0b want 0", req_ready);
    end
    checks++;
    if (pending !== '0) begin
      fails++; $display("FAIL rst_pending got %h want 0", pending);
    end
    checks++;
    if ({current_floor, nextfloor} !== 32'd0) begin
      fails++;
      $display("FAIL rst_floors got %0d/%0d want 0/0",
               current_floor, nextfloor);
    end
    checks++;
    if ({up, down, door_open, arrived, req_err} !== 5'b0) begin
      fails++;
      $display("FAIL rst_flags got %b want 00000",
               {up, down, door_open, arrived, req_err});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL rel_ready got %0b want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (pending !== 8'h20) begin
      fails++; $display("FAIL rel_accept got %h want 20", pending);
    end
  endtask

  task automatic test_single_trip();
    do_reset();
    request(3);
    checks++;
    if (pending !== 8'h08) begin
      fails++; $display("FAIL trip_pend got %h want 08", pending);
    end
    tick();
    checks++;
    if ({up, down, current_floor} !== {2'b10, 16'd0}) begin
      fails++;
      $display("FAIL trip_e1 got up%0b dn%0b fl%0d want up1 dn0 fl0",
               up, down, current_floor);
    end
    for (int k = 2; k <= 13; k++) begin
      tick();
      if (k % TC == 1) begin
        checks++;
        if (int'(current_floor) != (k - 1) / TC) begin
          fails++;
          $display("FAIL trip_step_e%0d got %0d want %0d",
                   k, current_floor, (k - 1) / TC);
        end
      end
    end
    checks++;
    if ({arrived, door_open, up, pending} !== {3'b110, 8'h00}) begin
      fails++;
      $display("FAIL trip_arrive got arr%0b door%0b up%0b pend%h",
               arrived, door_open, up, pending);
    end
    tick();
    checks++;
    if ({arrived, door_open} !== 2'b01) begin
      fails++;
      $display("FAIL trip_e14 got arr%0b door%0b want 0 1",
               arrived, door_open);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (door_open !== 1'b1) begin
      fails++; $display("FAIL trip_e18 got %0b want 1", door_open);
    end
    tick();
    checks++;
    if (door_open !== 1'b0) begin
      fails++; $display("FAIL trip_e19 got %0b want 0", door_open);
    end
  endtask

  task automatic test_scan();
    bit ok;
    do_reset();
    request(3);
    wait_arrival(ok);
    wait_door_closed(ok);
    request(6);
    request(1);
    tick();
    checks++;
    if ({nextfloor, up} !== {16'd6, 1'b1}) begin
      fails++;
      $display("FAIL scan_first got nf%0d up%0b want nf6 up1",
               nextfloor, up);
    end
    wait_arrival(ok);
    checks++;
    if (!ok || current_floor !== 16'd6 || pending !== 8'h02) begin
      fails++;
      $display("FAIL scan_serve6 got fl%0d pend%h want fl6 pend02",
               current_floor, pending);
    end
    wait_door_closed(ok);
    checks++;
    if (nextfloor !== 16'd1) begin
      fails++; $display("FAIL scan_next1 got %0d want 1", nextfloor);
    end
    tick();
    checks++;
    if ({up, down} !== 2'b01) begin
      fails++; $display("FAIL scan_rev got %b want 01", {up, down});
    end
    wait_arrival(ok);
    checks++;
    if (!ok || current_floor !== 16'd1 || pending !== 8'h00) begin
      fails++;
      $display("FAIL scan_serve1 got fl%0d pend%h want fl1 pend00",
               current_floor, pending);
    end
  endtask

  task automatic test_pass_through();
    bit ok;
    do_reset();
    request(5);
    wait_floor_up(1, ok);
    request(2);
    wait_arrival(ok);
    checks++;
    if (!ok || current_floor !== 16'd2 || pending !== 8'h20) begin
      fails++;
      $display("FAIL pass_stop2 got fl%0d pend%h want fl2 pend20",
               current_floor, pending);
    end
    wait_door_closed(ok);
    wait_arrival(ok);
    checks++;
    if (!ok || current_floor !== 16'd5 || pending !== 8'h00) begin
      fails++;
      $display("FAIL pass_stop5 got fl%0d pend%h want fl5 pend00",
               current_floor, pending);
    end
  endtask

  task automatic test_door_ext();
    bit ok;
    do_reset();
    request(2);
    wait_arrival(ok);
    tick(); tick(); tick();
    request(2);
    checks++;
    if ({door_open, pending} !== {1'b1, 8'h00}) begin
      fails++;
      $display("FAIL ext_req got door%0b pend%h want door1 pend00",
               door_open, pending);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (door_open !== 1'b1) begin
      fails++; $display("FAIL ext_hold got %0b want 1", door_open);
    end
    tick();
    checks++;
    if (door_open !== 1'b0) begin
      fails++; $display("FAIL ext_close got %0b want 0", door_open);
    end
    request(9);
    checks++;
    if ({req_err, pending} !== {1'b1, 8'h00}) begin
      fails++;
      $display("FAIL err_pulse got err%0b pend%h want err1 pend00",
               req_err, pending);
    end
    tick();
    checks++;
    if (req_err !== 1'b0) begin
      fails++; $display("FAIL err_drop got %0b want 0", req_err);
    end
  endtask

  task automatic test_reset_mid_move();
    bit ok;
    do_reset();
    request(5);
    wait_floor_up(2, ok);
    rst = 1'b1;
    tick();
    checks++;
    if (!ok || current_floor !== 16'd0 || up !== 1'b0
        || pending !== 8'h00) begin
      fails++;
      $display("FAIL midrst got fl%0d up%0b pend%h want fl0 up0 pend00",
               current_floor, up, pending);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [45:0] got, exp;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 399) == 0);
      req_valid = ($urandom_range(0, 99) < 25);
      req_floor = ($urandom_range(0, 29) == 0) ? 16'($urandom)
                                               : 16'($urandom_range(0, 9));
      tick();
      got = {current_floor, nextfloor, up, down, door_open,
             arrived, req_err, req_ready, pending};
      exp = {16'(m_floor), 16'(m_next), m_mode == 1 && m_dir,
             m_mode == 1 && !m_dir, m_mode == 2, m_arr, m_err,
             !rst, m_pend_vec()};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL rand_cyc%0d got %h want %h", n, got, exp);
      end
      checks++;
      if (int'(up) + int'(down) + int'(door_open) > 1) begin
        fails++;
        $display("FAIL rand_excl%0d got %b want onehot0",
                 n, {up, down, door_open});
      end
    end
    rst = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_floor = '0;
    test_reset();
    test_single_trip();
    test_scan();
    test_pass_through();
    test_door_ext();
    test_reset_mid_move();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Sequencing controller for the elevator car. It accepts floor requests through a valid/ready handshake and keeps them in a pending-request bitmask. It schedules service in SCAN (elevator) order and owns the car state: the current floor, travel timing, direction flags and door dwell. Its `current_floor`, `nextfloor`, `up` and `down` outputs are the same 16-bit floor / direction signals used by the request-sorting datapath.

## Interface
- `NUM_FLOORS`, 8: number of floors (0..NUM_FLOORS-1), 2..16.
- `TRAVEL_CYCLES`, 4: clock cycles to move one floor, ≥1.
- `DOOR_CYCLES`, 6: clock cycles the door stays open, ≥1.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  floor request present.
- `req_floor`  in  16  requested floor number.
- `req_ready`  out  1  request accepted on any edge with `req_valid`.
- `req_err`  out  1  one-cycle pulse: request dropped, floor out of range.
- `current_floor`  out  16  floor the car is at (last floor passed while moving).
- `nextfloor`  out  16  current SCAN target.
- `up`  out  1  car moving up.
- `down`  out  1  car moving down.
- `door_open`  out  1  door open.
- `arrived`  out  1  one-cycle pulse on stopping at a requested floor.
- `pending`  out  NUM_FLOORS  outstanding request bitmask.

## Operation
- Reset values:
  - `current_floor`, `nextfloor`, `pending` = 0.
  - `up`, `down`, `door_open`, `arrived`, `req_err` = 0.
  - `req_ready` = 0.
  - State = IDLE; direction register = UP; timers = 0.
- `req_ready` = !rst.
- Requests:
  - `req_valid && req_floor < NUM_FLOORS` sets `pending[req_floor]`.
  - Otherwise the request is dropped and `req_err` pulses.
  - Duplicate requests are idempotent.
- Request for `current_floor` while in DOOR: not recorded; door timer restarts.
- Same-edge set and clear of the same bit: clear wins.
- State IDLE (decision state, one cycle):
  - `pending[current_floor]`: clear bit, pulse `arrived`, go to DOOR.
  - Else requests exist ahead in the current direction: go to MOVE, same direction.
  - Else requests exist behind: flip direction, go to MOVE.
  - Else stay in IDLE.
- State MOVE:
  - `up` or `down` = direction.
  - The travel counter counts `TRAVEL_CYCLES`. On expiry, `current_floor` ±1 and the counter reloads.
  - On each floor step, if the new floor is pending: clear bit, pulse `arrived`, go to DOOR (`up`/`down` drop).
  - Else if requests remain ahead: stay in MOVE.
  - Else go to IDLE.
- State DOOR:
  - `door_open` = 1 for `DOOR_CYCLES` cycles, then IDLE.
  - Direction register is retained.
- `nextfloor` (registered, updated every cycle from `pending` and `current_floor`):
  - Nearest pending floor in the current direction.
  - Else nearest pending floor in the opposite direction.
  - Else `current_floor`.
- Car never leaves 0..NUM_FLOORS-1. Ahead/behind tests exclude out-of-range floors by construction.
- `rst` asserted mid-operation restores all reset values on that edge. The car is modelled as back at floor 0; no partial move is retained.

## Timing
- Request handshake:
  - Request sampled at edge E0; `pending` bit visible after E0.
  - IDLE acts on the bit at E1.
- Movement:
  - MOVE entered at E1; `up`/`down` high from E1.
  - Floor steps occur at E1+TRAVEL_CYCLES, E1+2·TRAVEL_CYCLES, …
- Door:
  - DOOR entered on the arrival edge; `door_open` high for exactly `DOOR_CYCLES` cycles.
  - Back in IDLE at arrival+DOOR_CYCLES.
- Signal exclusivity:
  - `up`, `down` and `door_open` are mutually exclusive.
  - `arrived` coincides with the first `door_open` cycle.
- `req_err` is asserted in the cycle after the offending request edge.

## Test plan
- **Reset:** hold `rst` 3 cycles with `req_valid`=1, floor 5 → all outputs 0, `pending`=0. First request accepted only after `rst` falls.
- **Single trip:** at floor 0 idle, request 3 at E0 → `up`=1 from E1. `current_floor` = 1/2/3 at E5/E9/E13. `arrived` and `door_open` at E13, `pending[3]` cleared. `door_open` falls at E19, IDLE.
- **SCAN order:** car idle at floor 3, direction UP; requests 1 and 6 on consecutive cycles → `nextfloor`=6. Car serves 6 first, then reverses; `nextfloor`=1; serves 1.
- **Pass-through stop:** moving 0→5 with a request for 2 injected before floor 2 is reached → stops at 2 (door cycle), then continues up to 5.
- **Door extension and error:**
  - Request the current floor on the 4th `door_open` cycle → door stays open 6 further cycles, `pending` unchanged.
  - Request floor 9 → `req_err` pulse, `pending` unchanged.
- **Reset mid-move:** assert `rst` while `up`=1 at floor 2 → next cycle `current_floor`=0, `up`=0, `pending`=0.
